fma_16: RTL and testbench
=========================

# fma_16

IEEE 754 binary16 (half-precision) fused multiply-add unit with a single rounding step. It computes ±(x·y ± z) with runtime-selectable multiply/add bypass, sign controls and one of four rounding modes. It is the arithmetic core under evaluation in the synthesis/power flow. The datapath is combinational and the result is registered, giving one cycle of latency.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- x  in  16  multiplicand, binary16.
- y  in  16  multiplier, binary16.
- z  in  16  addend, binary16.
- mul  in  1  1: use y; 0: treat y as +1.0 (0x3C00).
- add  in  1  1: use z; 0: treat z as +0.0.
- negr  in  1  negate the whole result: compute −(x·y' + z').
- negz  in  1  negate the addend before the add.
- roundmode  in  2  00 RZ (toward zero), 01 RNE (nearest-even), 10 RM (toward −∞), 11 RP (toward +∞).
- result  out  16  registered binary16 result.

## Operation
- Effective operands:
  - Y' = mul ? y : 0x3C00.
  - Z' = add ? z : 0x0000, then sign-flipped if negz.
- If negr is set, flip the signs of both the product and Z' before the add. Rounding is applied to the negated value, so RM/RP act on the final sign.
- Exact product (11×11 significand bits, 22-bit product), exact alignment and add, then a single rounding to binary16.
- The product is never rounded separately.
- Subnormal inputs and outputs are fully supported; there is no flush-to-zero.
- Special cases:
  - Any NaN input (among those in use) → canonical NaN 0x7E00.
  - ∞·0 → 0x7E00.
  - ∞ + (−∞) after sign handling → 0x7E00.
  - Otherwise ∞ propagates with its sign.
- Overflow by rounding mode:
  - RNE → ±∞ (0x7C00/0xFC00).
  - RZ → ±maxnorm (0x7BFF/0xFBFF).
  - RM: positive → 0x7BFF, negative → 0xFC00.
  - RP: positive → 0x7C00, negative → 0xFBFF.
- Underflow rounds to a subnormal or zero according to the mode. Ties under RNE go to the even significand.
- Exact-zero sum:
  - Opposite-sign operands → +0, except RM → −0.
  - Same-sign zeros keep their sign.
- No exception flags are produced.

## Timing
- Inputs are sampled at the rising clk edge. result reflects them from that edge until the next one (latency 1, throughput 1 per cycle).
- A new operation can start every cycle; no handshake is used.
- reset low asynchronously forces result = 0x0000 immediately, independent of clk, including mid-stream.
- While reset is low, result stays 0x0000.
- The first valid result appears at the first rising edge after reset deasserts.
- Control inputs (mul, add, negr, negz, roundmode) are sampled together with x, y and z in the same cycle.

## Test plan
- Basic FMA: x=0x4000 (2), y=0x4200 (3), z=0x3C00 (1), mul=add=1, RNE → 0x4700 (7.0) one cycle later. Same with negr=1 → 0xC700. With negz=1 → 0x4500 (5.0).
- Bypass modes:
  - mul=0, add=1, x=0x4000, z=0x3C00 → 0x4200.
  - mul=1, add=0, x=0x4000, y=0x4200 → 0x4600.
  - mul=0, add=0, x=0x3C00 → 0x3C00.
- Specials:
  - x=0x7C00, y=0x0000, add=0 → 0x7E00.
  - x=0x7E00 with any y, z → 0x7E00.
  - x=0x7C00, y=0x3C00, z=0xFC00, add=1 → 0x7E00.
- Overflow: x=0x7BFF, y=0x4000, add=0. RNE → 0x7C00; RZ → 0x7BFF; RM → 0x7BFF. With x=0xFBFF, RP → 0xFBFF.
- Zero sign and subnormals:
  - x=y=0x3C00, z=0xBC00: RNE → 0x0000; RM → 0x8000.
  - x=0x0001, y=0x3800, add=0: RNE → 0x0000 (tie to even); RP → 0x0001.
- Reset: drive random x, y, z each cycle, assert reset low mid-cycle → result becomes 0x0000 at once without a clock edge. Release reset → correct result after the next rising edge.

Source files
------------

// File: rtl/fma_16_if.sv
// Operand, control and result bundle for the binary16 fused multiply-add unit.
interface fma_16_if;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] z;
  logic        mul;
  logic        add;
  logic        negr;
  logic        negz;
  logic [1:0]  roundmode;
  logic [15:0] result;

  modport master (
    output x, y, z, mul, add, negr, negz, roundmode,
    input  result
  );

  modport slave (
    input  x, y, z, mul, add, negr, negz, roundmode,
    output result
  );
endinterface

// File: rtl/fma_16.sv
// Binary16 fused multiply-add, +/-(x*y' +/- z') with a single rounding step.
// Combinational datapath feeding one result register (latency 1, throughput 1).
module fma_16 (
  input  logic     clk,
  input  logic     reset,
  fma_16_if.slave  bus
);
  localparam int W = 82;

  logic [15:0]  yv, zv;
  logic         sp, sz, sr;
  logic [4:0]   ex, ey, ez;
  logic [10:0]  mx, my, mz;
  logic [21:0]  mp;
  logic [6:0]   pshift, zshift;
  logic         nan_any, inf_x, inf_y, inf_z, zero_x, zero_y, invalid;
  logic [W-1:0] pa, za, mag, low_mask;
  logic [6:0]   lead, q, qm1;
  logic [10:0]  sig;
  logic         rnd, sticky, inc, away;
  logic [16:0]  field;
  logic [15:0]  next;

  always_comb begin
    yv = bus.mul ? bus.y : 16'h3C00;
    zv = bus.add ? bus.z : 16'h0000;
    sp = bus.x[15] ^ yv[15] ^ bus.negr;
    sz = zv[15] ^ bus.negz ^ bus.negr;

    // Subnormals share the exponent of the smallest normal, without the hidden bit.
    ex = bus.x[14:10] | {4'b0, ~|bus.x[14:10]};
    ey = yv[14:10]    | {4'b0, ~|yv[14:10]};
    ez = zv[14:10]    | {4'b0, ~|zv[14:10]};
    mx = {|bus.x[14:10], bus.x[9:0]};
    my = {|yv[14:10], yv[9:0]};
    mz = {|zv[14:10], zv[9:0]};

    nan_any = (&bus.x[14:10] & |bus.x[9:0]) | (&yv[14:10] & |yv[9:0]) | (&zv[14:10] & |zv[9:0]);
    inf_x   = &bus.x[14:10] & ~|bus.x[9:0];
    inf_y   = &yv[14:10] & ~|yv[9:0];
    inf_z   = &zv[14:10] & ~|zv[9:0];
    zero_x  = ~|bus.x[14:0];
    zero_y  = ~|yv[14:0];
    invalid = nan_any | (inf_x & zero_y) | (zero_x & inf_y)
            | ((inf_x | inf_y) & inf_z & (sp != sz));

    // Exact sum as an unsigned fixed-point magnitude whose LSB weighs 2^-48.
    mp     = mx * my;
    pshift = 7'(ex) + 7'(ey) - 7'd2;
    zshift = 7'(ez) + 7'd23;
    pa     = W'(mp) << pshift;
    za     = W'(mz) << zshift;
    if (sp == sz) begin
      mag = pa + za;
      sr  = sp;
    end else if (pa >= za) begin
      mag = pa - za;
      sr  = sp;
    end else begin
      mag = za - pa;
      sr  = sz;
    end

    lead = '0;
    for (int i = 0; i < W; i++) begin
      if (mag[i]) lead = 7'(i);
    end

    // q is the weight of the result LSB; bit 24 is the subnormal quantum 2^-24.
    q        = (lead >= 7'd34) ? lead - 7'd10 : 7'd24;
    qm1      = q - 7'd1;
    sig      = 11'(mag >> q);
    rnd      = mag[qm1];
    low_mask = ~({W{1'b1}} << qm1);
    sticky   = |(mag & low_mask);

    case (bus.roundmode)
      2'b01:   inc = rnd & (sticky | sig[0]);
      2'b10:   inc = sr & (rnd | sticky);
      2'b11:   inc = ~sr & (rnd | sticky);
      default: inc = 1'b0;
    endcase
    away = (bus.roundmode == 2'b01) | ((bus.roundmode == 2'b10) & sr)
         | ((bus.roundmode == 2'b11) & ~sr);

    // A rounding carry out of the significand ripples straight into the exponent.
    field = ((17'(q) - 17'd24) << 10) + 17'(sig) + 17'(inc);

    if (invalid)
      next = 16'h7E00;
    else if (inf_x | inf_y)
      next = {sp, 15'h7C00};
    else if (inf_z)
      next = {sz, 15'h7C00};
    else if (mag == '0)
      next = {(sp == sz) ? sp : (bus.roundmode == 2'b10), 15'h0000};
    else if (field >= 17'h07C00)
      next = away ? {sr, 15'h7C00} : {sr, 15'h7BFF};
    else
      next = {sr, field[14:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bus.result <= 16'h0000;
    else
      bus.result <= next;
  end
endmodule

// File: tb/tb_fma_16.sv
// Scoreboard bench for fma_16: directed cases, randomized operations against an
// exact-arithmetic reference, and an asynchronous mid-cycle reset.
module tb_fma_16;
  logic clk;
  logic reset;
  logic in_valid;
  int   n_pass;
  int   n_total;

  typedef struct {
    logic [15:0] value;
    string       name;
  } exp_t;

  exp_t sb[$];

  fma_16_if bus ();

  fma_16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, result=%h", bus.result);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'h0);
  endfunction

  function automatic logic is_inf(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] == 10'h0);
  endfunction

  // Magnitude of a binary16 encoding as an integer count of 2^-48 units.
  function automatic logic [191:0] mag_of(input logic [15:0] h);
    int e;
    e = (h[14:10] == 5'h0) ? 1 : int'(h[14:10]);
    return 192'({h[14:10] != 5'h0, h[9:0]}) << (e + 23);
  endfunction

  // Exact value, then pick the neighbouring encodings by search and round between them.
  function automatic logic [15:0] ref_fma(input logic [15:0] a, b, c,
                                          input logic m, ad, nr, nz,
                                          input logic [1:0] rm);
    logic [15:0] bb, cc;
    logic ps, cs, rs;
    logic signed [199:0] pv, cv, v, av, lo_v, hi_v, t_v, d_lo, d_hi;
    int lo, hi, mid, k;
    bb = m ? b : 16'h3C00;
    cc = ad ? c : 16'h0000;
    ps = a[15] ^ bb[15] ^ nr;
    cs = cc[15] ^ nz ^ nr;
    if (is_nan(a) || is_nan(bb) || is_nan(cc)) return 16'h7E00;
    if ((is_inf(a) && bb[14:0] == 15'h0) || (a[14:0] == 15'h0 && is_inf(bb))) return 16'h7E00;
    if (is_inf(a) || is_inf(bb)) begin
      if (is_inf(cc) && cs != ps) return 16'h7E00;
      return {ps, 15'h7C00};
    end
    if (is_inf(cc)) return {cs, 15'h7C00};
    pv = 200'((mag_of(a) * mag_of(bb)) >> 48);
    cv = 200'(mag_of(cc));
    if (ps) pv = -pv;
    if (cs) cv = -cv;
    v = pv + cv;
    if (v == 0) return {(ps == cs) ? ps : (rm == 2'b10), 15'h0};
    rs = (v < 0);
    av = rs ? -v : v;
    lo = 0;
    hi = 16'h7BFF;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      t_v = 200'(mag_of(16'(mid)));
      if (t_v <= av) lo = mid;
      else hi = mid - 1;
    end
    lo_v = 200'(mag_of(16'(lo)));
    hi_v = 200'(mag_of(16'(lo + 1)));
    if (lo_v == av) k = lo;
    else begin
      case (rm)
        2'b01: begin
          d_lo = av - lo_v;
          d_hi = hi_v - av;
          k = (d_hi < d_lo || (d_hi == d_lo && (lo % 2) == 1)) ? lo + 1 : lo;
        end
        2'b10:   k = rs ? lo + 1 : lo;
        2'b11:   k = rs ? lo : lo + 1;
        default: k = lo;
      endcase
    end
    return {rs, 15'(k)};
  endfunction

  function automatic logic [15:0] rand_half(input int mode);
    logic [4:0] e;
    case (mode)
      1:       e = 5'($urandom_range(10, 20));
      2:       e = 5'($urandom_range(0, 4));
      default: e = 5'($urandom_range(0, 31));
    endcase
    return {1'($urandom_range(0, 1)), e, 10'($urandom)};
  endfunction

  task automatic applyStimulus(input logic [15:0] a, b, c,
                               input logic m, ad, nr, nz,
                               input logic [1:0] rm,
                               input logic [15:0] want,
                               input string name);
    exp_t e;
    @(negedge clk);
    bus.x = a;
    bus.y = b;
    bus.z = c;
    bus.mul = m;
    bus.add = ad;
    bus.negr = nr;
    bus.negz = nz;
    bus.roundmode = rm;
    e.value = want;
    e.name = name;
    sb.push_back(e);
    in_valid = 1'b1;
  endtask

  task automatic checkOutput();
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: result=%h expected=none", bus.result);
      return;
    end
    e = sb.pop_front();
    if (bus.result === e.value) n_pass++;
    else $display("[TB] FAIL %s: result=%h expected=%h", e.name, bus.result, e.value);
  endtask

  task automatic checkValue(input string name, input logic [15:0] want);
    n_total++;
    if (bus.result === want) n_pass++;
    else $display("[TB] FAIL %s: result=%h expected=%h", name, bus.result, want);
  endtask

  // Monitor: an operation captured at a rising edge is checked just after it.
  initial begin
    logic cap;
    forever begin
      @(posedge clk);
      cap = in_valid & reset;
      #1;
      if (cap) checkOutput();
    end
  end

  initial begin
    logic [15:0] a, b, c, r;
    logic m, ad, nr, nz;
    logic [1:0] rm;
    n_pass = 0;
    n_total = 0;
    in_valid = 1'b0;
    reset = 1'b0;
    bus.x = 16'h0;
    bus.y = 16'h0;
    bus.z = 16'h0;
    bus.mul = 1'b1;
    bus.add = 1'b1;
    bus.negr = 1'b0;
    bus.negz = 1'b0;
    bus.roundmode = 2'b01;
    #12;
    checkValue("reset_state", 16'h0000);
    #1 reset = 1'b1;

    applyStimulus(16'h4000, 16'h4200, 16'h3C00, 1, 1, 0, 0, 2'b01, 16'h4700, "fma_basic");
    applyStimulus(16'h4000, 16'h4200, 16'h3C00, 1, 1, 1, 0, 2'b01, 16'hC700, "fma_negr");
    applyStimulus(16'h4000, 16'h4200, 16'h3C00, 1, 1, 0, 1, 2'b01, 16'h4500, "fma_negz");
    applyStimulus(16'h4000, 16'($urandom), 16'h3C00, 0, 1, 0, 0, 2'b01, 16'h4200, "bypass_mul");
    applyStimulus(16'h4000, 16'h4200, 16'($urandom), 1, 0, 0, 0, 2'b01, 16'h4600, "bypass_add");
    applyStimulus(16'h3C00, 16'($urandom), 16'($urandom), 0, 0, 0, 0, 2'b01, 16'h3C00, "bypass_both");
    applyStimulus(16'h7C00, 16'h0000, 16'($urandom), 1, 0, 0, 0, 2'b01, 16'h7E00, "inf_times_zero");
    applyStimulus(16'h7E00, 16'($urandom), 16'($urandom), 1, 1, 0, 0, 2'b01, 16'h7E00, "nan_input");
    applyStimulus(16'h7C00, 16'h3C00, 16'hFC00, 1, 1, 0, 0, 2'b01, 16'h7E00, "inf_minus_inf");
    applyStimulus(16'h7BFF, 16'h4000, 16'h0000, 1, 0, 0, 0, 2'b01, 16'h7C00, "ovf_rne");
    applyStimulus(16'h7BFF, 16'h4000, 16'h0000, 1, 0, 0, 0, 2'b00, 16'h7BFF, "ovf_rz");
    applyStimulus(16'h7BFF, 16'h4000, 16'h0000, 1, 0, 0, 0, 2'b10, 16'h7BFF, "ovf_rm");
    applyStimulus(16'hFBFF, 16'h4000, 16'h0000, 1, 0, 0, 0, 2'b11, 16'hFBFF, "ovf_rp_neg");
    applyStimulus(16'h3C00, 16'h3C00, 16'hBC00, 1, 1, 0, 0, 2'b01, 16'h0000, "zero_rne");
    applyStimulus(16'h3C00, 16'h3C00, 16'hBC00, 1, 1, 0, 0, 2'b10, 16'h8000, "zero_rm");
    applyStimulus(16'h0001, 16'h3800, 16'h0000, 1, 0, 0, 0, 2'b01, 16'h0000, "sub_tie_rne");
    applyStimulus(16'h0001, 16'h3800, 16'h0000, 1, 0, 0, 0, 2'b11, 16'h0001, "sub_rp");

    for (int i = 0; i < 300; i++) begin
      a  = rand_half(i % 3);
      b  = rand_half(i % 3);
      c  = rand_half((i / 3) % 3);
      m  = ($urandom_range(0, 7) != 0);
      ad = ($urandom_range(0, 7) != 0);
      nr = 1'($urandom_range(0, 1));
      nz = 1'($urandom_range(0, 1));
      rm = 2'($urandom_range(0, 3));
      r  = ref_fma(a, b, c, m, ad, nr, nz, rm);
      applyStimulus(a, b, c, m, ad, nr, nz, rm, r, "random_op");
    end

    for (int i = 0; i < 4; i++) begin
      a = rand_half(1);
      b = rand_half(1);
      c = rand_half(1);
      applyStimulus(a, b, c, 1, 1, 0, 0, 2'b01, ref_fma(a, b, c, 1, 1, 0, 0, 2'b01), "pre_reset_op");
    end
    applyStimulus(16'h4000, 16'h4200, 16'h3C00, 1, 1, 0, 0, 2'b01, 16'h4700, "pre_reset_last");
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    bus.x = 16'($urandom);
    bus.y = 16'($urandom);
    bus.z = 16'($urandom);
    reset = 1'b0;
    #1;
    checkValue("async_reset", 16'h0000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.x = 16'($urandom);
      bus.y = 16'($urandom);
      bus.z = 16'($urandom);
      @(posedge clk);
      #1;
      checkValue("reset_hold", 16'h0000);
    end
    #2;
    reset = 1'b1;
    #1;
    checkValue("reset_release_no_edge", 16'h0000);
    applyStimulus(16'h4000, 16'h4200, 16'h3C00, 1, 1, 0, 1, 2'b01, 16'h4500, "post_reset_first");
    for (int i = 0; i < 3; i++) begin
      a = rand_half(1);
      b = rand_half(1);
      c = rand_half(1);
      rm = 2'($urandom_range(0, 3));
      applyStimulus(a, b, c, 1, 1, 0, 0, rm, ref_fma(a, b, c, 1, 1, 0, 0, rm), "post_reset_op");
    end

    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("[TB] FAIL scoreboard_drain: pending=%0d expected=0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
